// File: rtl/stopwatch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : stopwatch_pkg                                              |
// | Brief  : Mode encodings shared with the timer, debounce default     |
// | Rev    : 1.0                                                        |
// +--------------------------------------------------------------------+
package stopwatch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_LAP  = 2'b10,
        S_STOP = 2'b11
    } sw_state_t;

    localparam int c_db_cycles = 3;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : btn_debounce                                               |
// | Brief  : 2-flop synchroniser, stability counter, rising-edge pulse  |
// | Rev    : 1.0                                                        |
// +--------------------------------------------------------------------+
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES = c_db_cycles
) (
    input  logic msclk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    localparam logic [7:0] c_db_last = 8'(DB_CYCLES - 1);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_level;
    logic [7:0] r_cnt;
    logic       r_pulse;

    always_ff @(posedge msclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= 8'd0;
            r_pulse <= 1'b0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
            r_pulse <= 1'b0;
            if (r_sync2 != r_level) begin
                // Accept the new level on the DB_CYCLES-th consecutive mismatch
                if (r_cnt == c_db_last) begin
                    r_level <= r_sync2;
                    r_cnt   <= 8'd0;
                    r_pulse <= r_sync2;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end else begin
                r_cnt <= 8'd0;
            end
        end
    end

    assign pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : stopwatch_ctrl                                             |
// | Brief  : Button debounce, mode FSM and lap-hold display registers   |
// | Rev    : 1.0                                                        |
// +--------------------------------------------------------------------+
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES = c_db_cycles
) (
    input  logic       msclk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic [7:0] ms_in,
    input  logic [7:0] s_in,
    input  logic [7:0] m_in,
    output logic [1:0] state,
    output logic       running,
    output logic [7:0] disp_ms,
    output logic [7:0] disp_s,
    output logic [7:0] disp_m
);

    logic      w_start_p;
    logic      w_lap_p;
    sw_state_t r_state;
    logic [7:0] r_disp_ms;
    logic [7:0] r_disp_s;
    logic [7:0] r_disp_m;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
        .msclk (msclk),
        .rst_n (rst_n),
        .btn   (btn_start),
        .pulse (w_start_p)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
        .msclk (msclk),
        .rst_n (rst_n),
        .btn   (btn_lap),
        .pulse (w_lap_p)
    );

    always_ff @(posedge msclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_disp_ms <= 8'd0;
            r_disp_s  <= 8'd0;
            r_disp_m  <= 8'd0;
        end else begin
            // Display freezes only while in LAP; the RUN->LAP edge itself captures
            if (r_state != S_LAP) begin
                r_disp_ms <= ms_in;
                r_disp_s  <= s_in;
                r_disp_m  <= m_in;
            end
            // start_p has priority over a coincident lap_p
            if (w_start_p) begin
                case (r_state)
                    S_IDLE:  r_state <= S_RUN;
                    S_RUN:   r_state <= S_STOP;
                    S_LAP:   r_state <= S_STOP;
                    default: r_state <= S_RUN;
                endcase
            end else if (w_lap_p) begin
                case (r_state)
                    S_RUN:   r_state <= S_LAP;
                    S_LAP:   r_state <= S_RUN;
                    S_STOP:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign state   = r_state;
    assign running = (r_state == S_RUN) || (r_state == S_LAP);
    assign disp_ms = r_disp_ms;
    assign disp_s  = r_disp_s;
    assign disp_m  = r_disp_m;

endmodule
`default_nettype wire
